// File: rtl/vector_alu_sequencer_pkg.sv
// Shared processor package: scalar ALU opcodes and the vector sequencer FSM states.
package vector_alu_sequencer_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seqState_t;

endpackage

// File: rtl/vector_alu_sequencer_alu.sv
// Scalar N-bit ALU shared by every lane of the vector sequencer; only the zero flag is exported.
module vector_alu_sequencer_alu
    import vector_alu_sequencer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   aluControl,
    output logic [N-1:0] y,
    output logic         zero
);

    always_comb begin
        y = '0;
        case (aluControl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: runs one scalar lane ALU over L = V/N lanes, one lane per cycle,
// assembling the vector result in place. The FSM state is visible as the 'state' signal.
module vector_alu_sequencer
    import vector_alu_sequencer_pkg::*;
#(
    parameter int N = 32,
    parameter int V = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StartE,
    input  logic         FlushE,
    input  logic [2:0]   ALUControlE,
    input  logic [V-1:0] SrcAVE,
    input  logic [V-1:0] SrcBVE,
    output logic         AcceptE,
    output logic         BusyE,
    output logic         StallVE,
    output logic         DoneE,
    output logic [V-1:0] ALUResultVE,
    output logic         VZeroE
);

    localparam int L  = V / N;
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(L - 1);

    seqState_t     state, stateNext;
    logic [CW-1:0] laneCnt;
    logic [V-1:0]  srcAReg, srcBReg, resultReg;
    logic [2:0]    opReg;
    logic          zeroAcc;
    logic [N-1:0]  laneA, laneB, laneY;
    logic          laneZero;
    logic          acceptInt, laneWrite, lastLane;

    // Handshake: StartE is a request held by the requester; the transfer happens in the
    // cycle AcceptE=1 (IDLE, no flush), and operands/opcode are captured at that edge only.
    assign acceptInt = (state == IDLE) && StartE && !FlushE && !rst;
    assign laneWrite = (state == RUN) && !FlushE;
    assign lastLane  = (laneCnt == LAST_LANE);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (acceptInt) stateNext = RUN;
            RUN:     if (FlushE) stateNext = IDLE;
                     else if (lastLane) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        laneA = '0;
        laneB = '0;
        for (int i = 0; i < L; i++) begin
            if (laneCnt == CW'(i)) begin
                laneA = srcAReg[i*N +: N];
                laneB = srcBReg[i*N +: N];
            end
        end
    end

    vector_alu_sequencer_alu #(.N(N)) laneAlu (
        .a          (laneA),
        .b          (laneB),
        .aluControl (opReg),
        .y          (laneY),
        .zero       (laneZero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            laneCnt   <= '0;
            srcAReg   <= '0;
            srcBReg   <= '0;
            opReg     <= '0;
            resultReg <= '0;
            zeroAcc   <= 1'b0;
            VZeroE    <= 1'b0;
        end else begin
            state <= stateNext;
            if (acceptInt) begin
                srcAReg <= SrcAVE;
                srcBReg <= SrcBVE;
                opReg   <= ALUControlE;
                laneCnt <= '0;
                zeroAcc <= 1'b1;
                VZeroE  <= 1'b0;
            end else if (laneWrite) begin
                for (int i = 0; i < L; i++) begin
                    if (laneCnt == CW'(i)) resultReg[i*N +: N] <= laneY;
                end
                zeroAcc <= zeroAcc & laneZero;
                // The counter parks on the last lane instead of wrapping.
                if (lastLane) VZeroE <= zeroAcc & laneZero;
                else          laneCnt <= laneCnt + 1'b1;
            end
        end
    end

    assign AcceptE     = acceptInt;
    assign BusyE       = (state == RUN) || (state == DONE);
    assign StallVE     = acceptInt || (state == RUN);
    assign DoneE       = (state == DONE);
    assign ALUResultVE = resultReg;

endmodule
